// File: rtl/frame_buf_sched_pkg.sv
// Shared definitions for the triple-buffer frame scheduler: slot index type,
// reset role encodings and default SDRAM frame-store layout.
package frame_buf_sched_pkg;

    localparam int SLOT_W = 2;

    typedef logic [SLOT_W-1:0] slot_t;

    // Reset roles: reader on slot 0, writer on slot 1, pending on slot 2
    localparam slot_t RST_R_IDX = 2'd0;
    localparam slot_t RST_W_IDX = 2'd1;
    localparam slot_t RST_P_IDX = 2'd2;

    // Default frame-store layout, shared with DMA channels and driver headers
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;
    localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0004_0000;

endpackage

// File: rtl/frame_buf_sched_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Count register; holds once the all-ones value is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {CNT_W{1'b0}};
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + CNT_ONE;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler for the SDRAM frame store. Rotates three slot roles
// (write, read, pending) so the writer never touches the displayed frame and
// the reader always picks up the newest complete frame.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = DEF_BASE_ADDR,
    parameter logic [ADDR_W-1:0]  FRAME_STRIDE = DEF_FRAME_STRIDE,
    parameter int                 CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr_frame_start,
    input  logic              wr_frame_done,
    input  logic              rd_frame_start,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic [1:0]        wr_idx,
    output logic [1:0]        rd_idx,
    output logic              wr_active,
    output logic              rd_new_frame,
    output logic              err_wr_seq,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  rep_cnt
);

    // Slot bases built by addition only, so no multiplier is inferred
    localparam logic [ADDR_W-1:0] SLOT0_BASE = BASE_ADDR;
    localparam logic [ADDR_W-1:0] SLOT1_BASE = BASE_ADDR + FRAME_STRIDE;
    localparam logic [ADDR_W-1:0] SLOT2_BASE = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;

    // Constant 3-way mux; the unreachable index 3 falls back to slot 0
    function automatic logic [ADDR_W-1:0] slot_base(input slot_t idx);
        logic [ADDR_W-1:0] base;
        case (idx)
            2'd0:    base = SLOT0_BASE;
            2'd1:    base = SLOT1_BASE;
            2'd2:    base = SLOT2_BASE;
            default: base = SLOT0_BASE;
        endcase
        return base;
    endfunction

    slot_t             w_idx_r, r_idx_r, p_idx_r;
    logic              p_valid_r, wr_active_r, rd_new_r, err_r;
    logic [ADDR_W-1:0] wr_base_r, rd_base_r;

    slot_t             w_idx_s, r_idx_s, p_idx_s, swap_tmp_s;
    logic              p_valid_s, wr_active_s, rd_new_s, err_s;
    logic              drop_inc_s, rep_inc_s;

    // Event processing in order: write done, write start, read start
    always_comb begin
        w_idx_s     = w_idx_r;
        r_idx_s     = r_idx_r;
        p_idx_s     = p_idx_r;
        swap_tmp_s  = w_idx_r;
        p_valid_s   = p_valid_r;
        wr_active_s = wr_active_r;
        rd_new_s    = 1'b0;
        err_s       = 1'b0;
        drop_inc_s  = 1'b0;
        rep_inc_s   = 1'b0;

        if (!enable) begin
            wr_active_s = 1'b0;
        end else begin
            // Completed frame becomes pending; an unread pending frame is lost
            if (wr_frame_done) begin
                if (wr_active_s) begin
                    swap_tmp_s  = w_idx_s;
                    w_idx_s     = p_idx_s;
                    p_idx_s     = swap_tmp_s;
                    drop_inc_s  = p_valid_s;
                    p_valid_s   = 1'b1;
                    wr_active_s = 1'b0;
                end else begin
                    err_s = 1'b1;
                end
            end else begin
                err_s = err_s;
            end

            // A start while already active restarts into the same slot
            if (wr_frame_start) begin
                if (wr_active_s) begin
                    err_s = 1'b1;
                end else begin
                    wr_active_s = 1'b1;
                end
            end else begin
                wr_active_s = wr_active_s;
            end

            // Reader takes the pending frame if one exists, else repeats
            if (rd_frame_start) begin
                if (p_valid_s) begin
                    swap_tmp_s = r_idx_s;
                    r_idx_s    = p_idx_s;
                    p_idx_s    = swap_tmp_s;
                    p_valid_s  = 1'b0;
                    rd_new_s   = 1'b1;
                end else begin
                    rep_inc_s = 1'b1;
                end
            end else begin
                rep_inc_s = 1'b0;
            end
        end
    end

    // Role, flag and base-address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_idx_r     <= RST_W_IDX;
            r_idx_r     <= RST_R_IDX;
            p_idx_r     <= RST_P_IDX;
            p_valid_r   <= 1'b0;
            wr_active_r <= 1'b0;
            rd_new_r    <= 1'b0;
            err_r       <= 1'b0;
            wr_base_r   <= SLOT1_BASE;
            rd_base_r   <= SLOT0_BASE;
        end else begin
            w_idx_r     <= w_idx_s;
            r_idx_r     <= r_idx_s;
            p_idx_r     <= p_idx_s;
            p_valid_r   <= p_valid_s;
            wr_active_r <= wr_active_s;
            rd_new_r    <= rd_new_s;
            err_r       <= err_s;
            wr_base_r   <= slot_base(w_idx_s);
            rd_base_r   <= slot_base(r_idx_s);
        end
    end

    sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (drop_inc_s),
        .q     (drop_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rep_inc_s),
        .q     (rep_cnt)
    );

    assign wr_idx       = w_idx_r;
    assign rd_idx       = r_idx_r;
    assign wr_active    = wr_active_r;
    assign rd_new_frame = rd_new_r;
    assign err_wr_seq   = err_r;
    assign wr_base      = wr_base_r;
    assign rd_base      = rd_base_r;

endmodule
